// File: rtl/data_mem_access_unit_pkg.sv
// Shared decoder/memory-stage definitions: access-size codes and the access FSM encoding.
package mips_pkg;
    localparam logic [1:0] DS_WORD = 2'b00;
    localparam logic [1:0] DS_BYTE = 2'b01;
    localparam logic [1:0] DS_HALF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Size code 2'b11 behaves as a full word.
    function automatic logic is_word(input logic [1:0] ds);
        return (ds == DS_WORD) || (ds == 2'b11);
    endfunction

    // Lane offset with the bits below the access size cleared.
    function automatic logic [1:0] align_off(input logic [1:0] ds, input logic [1:0] a);
        if (ds == DS_BYTE) return a;
        if (ds == DS_HALF) return {a[1], 1'b0};
        return 2'b00;
    endfunction
endpackage

// File: rtl/data_mem_access_unit_if.sv
// Word-only data memory port: registered request from the unit, one-cycle ack from memory.
interface data_mem_access_unit_if #(parameter int ADDR_W = 30) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/data_mem_access_unit_lane_align.sv
// Combinational lane logic: load extract + sign-extend, and sub-word store merge into a read word.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sh     = {off_i, 3'b000};
    assign lane_b = 8'(rdata_i >> sh);
    assign lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        load_o  = rdata_i;
        merge_o = wdata_i;
        case (size_i)
            DS_BYTE: begin
                load_o  = {{24{lane_b[7]}}, lane_b};
                merge_o = (rdata_i & ~(32'h0000_00FF << sh)) | ({24'd0, wdata_i[7:0]} << sh);
            end
            DS_HALF: begin
                load_o  = {{16{lane_h[15]}}, lane_h};
                merge_o = (rdata_i & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata_i[15:0]} << sh);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-stage load/store responder with RMW for sub-word stores and pipeline stall.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module data_mem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic [1:0]  data_size_M,
    input  logic [31:0] ALU_Result_M,
    input  logic [31:0] Write_Data_M,
    output logic [31:0] Read_Data_M,
    output logic        Stall_M,
`ifdef MISALIGN_TRAP_EN
    output logic        Misalign_Exc_M,
`endif
    data_mem_access_unit_if.master mem
);
    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, sdata_q, sdata_d, rdata_q, rdata_d;
    logic [1:0]        size_q, size_d, off_q, off_d;
    logic              exc_q, exc_d;
    logic [31:0]       load_val, merge_val;
    logic              misal;

`ifdef MISALIGN_TRAP_EN
    assign misal = ((data_size_M == DS_HALF) && ALU_Result_M[0]) ||
                   (is_word(data_size_M) && (ALU_Result_M[1:0] != 2'b00));
    assign Misalign_Exc_M = exc_q;
`else
    assign misal = 1'b0;
`endif

    mem_lane_align u_align (
        .rdata_i (mem.mem_rdata),
        .wdata_i (sdata_q),
        .size_i  (size_q),
        .off_i   (off_q),
        .load_o  (load_val),
        .merge_o (merge_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sdata_q <= '0;
            rdata_q <= '0;
            size_q  <= DS_WORD;
            off_q   <= 2'b00;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sdata_q <= sdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        store_d = store_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sdata_d = sdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        off_d   = off_q;
        exc_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Mem_Write_M || Mem_Read_M) begin
                    addr_d  = ALU_Result_M[ADDR_W+1:2];
                    size_d  = data_size_M;
                    off_d   = align_off(data_size_M, ALU_Result_M[1:0]);
                    store_d = Mem_Write_M;
                    sdata_d = Write_Data_M;
                    if (misal) begin
                        state_d = ST_DONE;
                        exc_d   = 1'b1;
                    end else if (Mem_Write_M && is_word(data_size_M)) begin
                        state_d = ST_WR;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = Write_Data_M;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d = ST_RD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (mem.mem_ack) begin
                    if (store_q) begin
                        state_d = ST_WR;
                        we_d    = 1'b1;
                        wdata_d = merge_val;
                    end else begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                        rdata_d = load_val;
                    end
                end
            end
            ST_WR: begin
                if (mem.mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Stall_M       = ((state_q == ST_IDLE) && (Mem_Read_M || Mem_Write_M)) ||
                           (state_q == ST_RD) || (state_q == ST_WR);
    assign Read_Data_M   = rdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed spec cases plus random loads/stores against a word-array model.
module tb_data_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Mem_Read_M, Mem_Write_M;
    logic [1:0]  data_size_M;
    logic [31:0] ALU_Result_M, Write_Data_M, Read_Data_M;
    logic        Stall_M, exc;

    data_mem_access_unit_if #(.ADDR_W(30)) mif ();

    data_mem_access_unit #(.ADDR_W(30)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Mem_Read_M   (Mem_Read_M),
        .Mem_Write_M  (Mem_Write_M),
        .data_size_M  (data_size_M),
        .ALU_Result_M (ALU_Result_M),
        .Write_Data_M (Write_Data_M),
        .Read_Data_M  (Read_Data_M),
        .Stall_M      (Stall_M),
`ifdef MISALIGN_TRAP_EN
        .Misalign_Exc_M (exc),
`endif
        .mem          (mif.master)
    );
`ifndef MISALIGN_TRAP_EN
    assign exc = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int total = 0, bad = 0, nrd = 0, nwr = 0, stab_err = 0, ack_wait = 0, cnt = 0;
    bit stale_ack = 0, prev_req = 0, prev_ack = 0, hit = 0, trap_en = 0;
    logic [29:0] l_addr;
    logic        l_we;
    logic [31:0] l_wdata, exp_rd = 0;
    int          stalls;
    logic        done_exc;

    // Memory responder: each request (including back-to-back RMW halves) acks after ack_wait wait cycles.
    always begin
        @(posedge clk); #1;
        if (mif.mem_req) begin
            if (!prev_req || prev_ack) begin
                cnt = 0; l_addr = mif.mem_addr; l_we = mif.mem_we; l_wdata = mif.mem_wdata;
            end else begin
                cnt++;
                if (mif.mem_addr !== l_addr || mif.mem_we !== l_we || (l_we && mif.mem_wdata !== l_wdata))
                    stab_err++;
            end
        end else cnt = 0;
        hit = mif.mem_req && (cnt == ack_wait);
        mif.mem_rdata = 32'h0;
        if (hit) begin
            if (mif.mem_we) begin mem[mif.mem_addr[7:0]] = mif.mem_wdata; nwr++; end
            else begin mif.mem_rdata = mem[mif.mem_addr[7:0]]; nrd++; end
        end
        if (stale_ack) mif.mem_rdata = 32'h5555_5555;
        mif.mem_ack = hit || stale_ack;
        prev_req = mif.mem_req;
        prev_ack = hit;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] ds, input int unsigned a);
        int unsigned v;
        if (ds == 2'd1) begin
            v = (w >> (8 * (a % 4))) % 256;
            if (v >= 128) v = v + 32'hFFFF_FF00;
        end else if (ds == 2'd2) begin
            v = (w >> (16 * ((a / 2) % 2))) % 65536;
            if (v >= 32768) v = v + 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] ds, input int unsigned a);
        int unsigned sh, m;
        if (ds == 2'd1) begin sh = 8 * (a % 4); m = 255; end
        else if (ds == 2'd2) begin sh = 16 * ((a / 2) % 2); m = 65535; end
        else return d;
        return (old & ~(m << sh)) | ((d & m) << sh);
    endfunction

    // Drive one instruction into M, count stall cycles, release after the DONE cycle.
    task automatic access(input bit r, input bit w, input logic [1:0] ds, input logic [31:0] a,
                          input logic [31:0] wd, input int wt);
        ack_wait = wt;
        Mem_Read_M = r; Mem_Write_M = w; data_size_M = ds; ALU_Result_M = a; Write_Data_M = wd;
        stalls = 0;
        @(negedge clk);
        while (Stall_M === 1'b1 && stalls < 60) begin stalls++; @(negedge clk); end
        if (stalls >= 60) check("timeout", 32'(stalls), 32'd0);
        done_exc = exc;
        @(posedge clk); #1;
        Mem_Read_M = 1'b0; Mem_Write_M = 1'b0;
    endtask

    // Run one access and compare against the array model.
    task automatic run(input string tag, input bit r, input bit w, input logic [1:0] ds,
                       input int unsigned a, input logic [31:0] wd, input int wt);
        int unsigned ea, wi, er, ew, es;
        bit mis, word;
        int rd0, wr0;
        word = (ds == 2'd0) || (ds == 2'd3);
        mis  = trap_en && (((ds == 2'd2) && (a % 2 != 0)) || (word && (a % 4 != 0)));
        ea   = word ? (a & ~32'd3) : (ds == 2'd2) ? (a & ~32'd1) : a;
        wi   = (ea / 4) % 256;
        rd0 = nrd; wr0 = nwr;
        access(r, w, ds, a, wd, wt);
        if (mis) begin er = 0; ew = 0; es = 1; end
        else if (w && word) begin er = 0; ew = 1; es = 2 + wt; ref_mem[wi] = wd; end
        else if (w) begin er = 1; ew = 1; es = 3 + 2 * wt; ref_mem[wi] = ref_store(ref_mem[wi], wd, ds, ea); end
        else begin er = 1; ew = 0; es = 2 + wt; exp_rd = ref_load(ref_mem[wi], ds, ea); end
        check({tag, ".rdata"}, Read_Data_M, exp_rd);
        check({tag, ".stall"}, 32'(stalls), es);
        check({tag, ".reads"}, 32'(nrd - rd0), er);
        check({tag, ".writes"}, 32'(nwr - wr0), ew);
        check({tag, ".mem"}, mem[wi], ref_mem[wi]);
        check({tag, ".exc"}, {31'd0, done_exc}, {31'd0, mis});
    endtask

    task automatic preload(input int unsigned a, input logic [31:0] v);
        mem[(a / 4) % 256] = v; ref_mem[(a / 4) % 256] = v;
    endtask

    initial begin
`ifdef MISALIGN_TRAP_EN
        trap_en = 1;
`endif
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        rst_n = 1'b0; Mem_Read_M = 0; Mem_Write_M = 0; data_size_M = 0; ALU_Result_M = 0; Write_Data_M = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.rdata", Read_Data_M, 32'h0);
        check("rst.req", {31'd0, mif.mem_req}, 32'd0);
        check("rst.we", {31'd0, mif.mem_we}, 32'd0);
        check("rst.addr", {2'b0, mif.mem_addr}, 32'h0);
        check("rst.stall", {31'd0, Stall_M}, 32'd0);
        check("rst.exc", {31'd0, exc}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        preload(32'h100, 32'hDEAD_BEEF);
        run("lw_slow", 1, 0, 2'd0, 32'h100, 0, 2);
        check("lw_slow.val", Read_Data_M, 32'hDEAD_BEEF);
        check("lw_slow.stall4", 32'(stalls), 32'd4);

        preload(32'h100, 32'h8011_2233);
        run("lb103", 1, 0, 2'd1, 32'h103, 0, 0);
        check("lb103.val", Read_Data_M, 32'hFFFF_FF80);
        run("lh102", 1, 0, 2'd2, 32'h102, 0, 0);
        check("lh102.val", Read_Data_M, 32'hFFFF_8011);
        run("lb100", 1, 0, 2'd1, 32'h100, 0, 0);
        check("lb100.val", Read_Data_M, 32'h0000_0033);

        preload(32'h100, 32'h1122_3344);
        run("sb101", 0, 1, 2'd1, 32'h101, 32'h0000_00AB, 0);
        check("sb101.word", mem[8'h40], 32'h1122_AB44);
        preload(32'h100, 32'h1122_3344);
        run("sh102", 0, 1, 2'd2, 32'h102, 32'h0000_CAFE, 1);
        check("sh102.word", mem[8'h40], 32'hCAFE_3344);
        run("sw200", 0, 1, 2'd0, 32'h200, 32'h1234_5678, 0);
        check("sw200.word", mem[8'h80], 32'h1234_5678);
        check("sw200.stall2", 32'(stalls), 32'd2);

        // Reset while waiting in RD, then a stale ack in IDLE.
        ack_wait = 1000;
        Mem_Read_M = 1; data_size_M = 2'd0; ALU_Result_M = 32'h100;
        repeat (3) @(negedge clk);
        check("mid.stall", {31'd0, Stall_M}, 32'd1);
        @(posedge clk); #1; rst_n = 1'b0; Mem_Read_M = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; exp_rd = 32'h0;
        @(negedge clk);
        check("mid.req", {31'd0, mif.mem_req}, 32'd0);
        check("mid.stall0", {31'd0, Stall_M}, 32'd0);
        check("mid.rdata", Read_Data_M, 32'h0);
        stale_ack = 1'b1;
        @(posedge clk); @(negedge clk); stale_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        check("stale.rdata", Read_Data_M, 32'h0);
        check("stale.req", {31'd0, mif.mem_req}, 32'd0);
        @(posedge clk); #1;
        preload(32'h100, 32'hA5A5_0F0F);
        run("lw_after_rst", 1, 0, 2'd0, 32'h100, 0, 0);

        run("lw102", 1, 0, 2'd0, 32'h102, 0, 0);
        run("lh101", 1, 0, 2'd2, 32'h101, 0, 1);
        run("sw103", 0, 1, 2'd3, 32'h103, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 40; i++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
            run($sformatf("rnd%0d", i), r, w, 2'($urandom_range(0, 3)), 32'h300 + $urandom_range(0, 15),
                $urandom, $urandom_range(0, 3));
        end
        check("bus.stable", 32'(stab_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
